// File: rtl/pwm_duty_sequencer.sv
// Steps a small duty-cycle table out to a PWM generator, one entry per HOLD_PERIODS
// PWM periods of 256 clocks, with single-pass/loop control and a draining stop.
module pwm_duty_sequencer #(
   parameter int DEPTH        = 8,
   parameter int HOLD_PERIODS = 1
) (
   input  logic       clk_50M,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [3:0] wr_data,
   input  logic [2:0] seq_len,
   input  logic       loop,
   input  logic       start,
   input  logic       stop,
   output logic [3:0] duty_cycle,
   output logic       period_start,
   output logic [2:0] seq_index,
   output logic       busy,
   output logic       done,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] phase_q, phase_d;
   logic [7:0] hold_q, hold_d;
   logic [2:0] idx_q, idx_d;
   logic [3:0] duty_q, duty_d;
   logic       ps_q, ps_d;
   logic       done_q, done_d;
   logic [3:0] table_q [DEPTH];

   logic       boundary;
   logic       hold_last;
   logic       at_last;
   logic [2:0] next_idx;
   logic [3:0] next_entry;
   logic [3:0] first_entry;

   // The edge that wraps phase 255->0 is the period boundary; its effects show with period_start.
   assign boundary    = (phase_q == 8'hFF);
   assign hold_last   = (hold_q == 8'(HOLD_PERIODS - 1));
   assign at_last     = !(idx_q < seq_len);
   assign next_idx    = at_last ? 3'd0 : idx_q + 3'd1;
   assign next_entry  = (32'(next_idx) < DEPTH) ? table_q[next_idx] : 4'd0;
   assign first_entry = table_q[0];

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (boundary) begin
               if (stop || (hold_last && at_last && !loop)) state_d = ST_IDLE;
            end else if (stop) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (boundary) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      phase_d = phase_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      duty_d  = duty_q;
      ps_d    = 1'b0;
      done_d  = 1'b0;
      if (state_q == ST_IDLE) begin
         if (start) begin
            phase_d = 8'd0;
            hold_d  = 8'd0;
            idx_d   = 3'd0;
            duty_d  = first_entry;
            ps_d    = 1'b1;
         end
      end else begin
         phase_d = phase_q + 8'd1;
         if (state_d == ST_IDLE) begin
            phase_d = 8'd0;
            hold_d  = 8'd0;
            idx_d   = 3'd0;
            duty_d  = 4'd0;
            done_d  = 1'b1;
         end else if (boundary) begin
            ps_d = 1'b1;
            if (hold_last) begin
               hold_d = 8'd0;
               idx_d  = next_idx;
               duty_d = next_entry;
            end else begin
               hold_d = hold_q + 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         phase_q <= 8'd0;
         hold_q  <= 8'd0;
         idx_q   <= 3'd0;
         duty_q  <= 4'd0;
         ps_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         phase_q <= phase_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         duty_q  <= duty_d;
         ps_q    <= ps_d;
         done_q  <= done_d;
      end
   end

   // Loads read the registered entry, so a same-cycle write lands for the next load only.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) table_q[i] <= 4'd0;
      end else if (wr_en && (32'(wr_addr) < DEPTH)) begin
         table_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      duty_cycle   = duty_q;
      period_start = ps_q;
      seq_index    = idx_q;
      busy         = (state_q != ST_IDLE);
      done         = done_q;
      state_dbg    = state_q;
   end

endmodule

// File: doc/pwm_duty_sequencer.md
PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, giving the number of duty-table entries.
REQ-002 The block SHALL have parameter HOLD_PERIODS, default 1, giving the number of PWM periods each entry is applied (legal range 1..255).
REQ-003 The block SHALL have port clk_50M  input  1  system clock, 50 MHz.
REQ-004 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port wr_en  input  1  table write strobe.
REQ-006 The block SHALL have port wr_addr  input  3  table write index.
REQ-007 The block SHALL have port wr_data  input  4  duty value to write (0..15, in 1/16 steps).
REQ-008 The block SHALL have port seq_len  input  3  index of the last active entry (sequence covers 0..seq_len).
REQ-009 The block SHALL have port loop  input  1  1 = restart at entry 0 after the last entry; 0 = single pass.
REQ-010 The block SHALL have port start  input  1  one-cycle start request.
REQ-011 The block SHALL have port stop  input  1  one-cycle stop request.
REQ-012 The block SHALL have port duty_cycle  output  4  registered duty value driven to the PWM generator.
REQ-013 The block SHALL have port period_start  output  1  one-cycle pulse on the first clock of each 5120 ns PWM period.
REQ-014 The block SHALL have port seq_index  output  3  table index currently applied.
REQ-015 The block SHALL have port busy  output  1  high in the RUN and DRAIN states.
REQ-016 The block SHALL have port done  output  1  one-cycle pulse on return to IDLE.

Function
REQ-017 The block SHALL implement states IDLE, RUN and DRAIN.
REQ-018 The block SHALL hold an 8-bit phase counter, where 256 clk_50M cycles = 16 steps of 3.125 MHz = one PWM period.
REQ-019 Transition IDLE->RUN on start: next cycle phase=0, seq_index=0, hold count=0, duty_cycle=table[0], period_start=1 (latency 1 clock).
REQ-020 In RUN and DRAIN, phase SHALL increment every clock and wrap 255->0; a wrap is a period boundary and period_start SHALL pulse in the cycle phase equals 0.
REQ-021 At each boundary in RUN, the hold count SHALL increment; when it reaches HOLD_PERIODS, it SHALL clear and seq_index SHALL advance.
REQ-022 The advance rule SHALL be: index<seq_len -> index+1; index==seq_len with loop=1 -> index 0; index==seq_len with loop=0 -> IDLE.
REQ-023 duty_cycle SHALL change only in a cycle where period_start=1 or on entry to IDLE, never mid-period.
REQ-024 duty_cycle SHALL be loaded from table[new index] at each advance; the value is passed through unmodified, with no saturation.
REQ-025 A stop in RUN SHALL move the block to DRAIN; the current period completes, and at the next boundary the block goes to IDLE.
REQ-026 Entry to IDLE SHALL set duty_cycle=0, phase=0, seq_index=0, busy=0, and pulse done=1 for one cycle.
REQ-027 start while busy=1 SHALL be ignored; stop in IDLE or DRAIN SHALL be ignored.
REQ-028 If start and stop are asserted together in IDLE, start SHALL be accepted.
REQ-029 If stop coincides with a boundary cycle, the boundary SHALL be processed as the last period end and the block SHALL enter IDLE, with no further period.
REQ-030 Table writes SHALL be accepted in any state.
REQ-031 If a table write and a load of the same address occur in the same cycle, the load SHALL take the old value; the new value is used on the next load.
REQ-032 A seq_len or loop change during RUN SHALL take effect at the next advance decision.

Reset
REQ-033 While rst_n=0, the block SHALL immediately force: state IDLE, duty_cycle=0, period_start=0, seq_index=0, busy=0, done=0, phase=0, hold count=0, all table entries=0.
REQ-034 Reset asserted mid-RUN SHALL abort the sequence with no done pulse.
REQ-035 After rst_n release, the block SHALL accept start on the first clock edge.

Verification
REQ-036 Load table {8,11,4,12,10,5,9,11}, seq_len=7, loop=0, HOLD_PERIODS=1, start -> duty_cycle steps 8,11,4,12,10,5,9,11 every 256 clocks, each change coincident with period_start; at 2048 clocks after start: duty_cycle=0, done pulse, busy=0.
REQ-037 Same table with loop=1 -> after entry 7, seq_index=0 and duty_cycle=8 at clock 2048; no done pulse; busy stays 1.
REQ-038 stop at phase 100 of entry 2 -> duty_cycle stays 4 until phase wraps 156 clocks later, then duty_cycle=0 and one done pulse.
REQ-039 start pulse during RUN -> no restart, seq_index continues; write table[3]=2 while seq_index=1 -> duty_cycle=2 when index 3 loads.
REQ-040 HOLD_PERIODS=3, seq_len=1 -> each entry held 768 clocks, done at clock 1536.
REQ-041 rst_n low at an arbitrary RUN cycle -> all outputs 0 in the same cycle, table cleared, no done pulse.
